// File: rtl/rf_wr_arbiter_pkg.sv
// Shared constants and port encoding for the register-file write-port arbiter.
// DW must match the register file write-data width.
package rf_wr_arbiter_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  typedef enum logic {
    PORT_EX  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding buffer for a writeback requester: destination, data and an
// age flag that marks the other port's entry as older.
module rf_wr_slot #(
  parameter int unsigned DW = rf_wr_arbiter_pkg::DW,
  parameter int unsigned AW = rf_wr_arbiter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          grant,
  input  logic          clear_age,
  input  logic          set_age,
  input  logic [AW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  output logic          full,
  output logic [AW-1:0] buf_reg,
  output logic [DW-1:0] buf_data,
  output logic          age
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      buf_reg  <= '0;
      buf_data <= '0;
      age      <= 1'b0;
    end else if (load) begin
      // A load may coincide with a grant: the outgoing entry is replaced in place.
      full     <= 1'b1;
      buf_reg  <= in_reg;
      buf_data <= in_data;
      age      <= set_age;
    end else begin
      if (grant) begin
        full <= 1'b0;
      end
      // Once the other entry leaves, this one is the oldest.
      if (grant || clear_age) begin
        age <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the register file's single write port between the execute (port 0)
// and memory (port 1) writeback paths, preserving write order and flagging WAW clashes.
module rf_wr_arbiter #(
  parameter int unsigned DW = rf_wr_arbiter_pkg::DW,
  parameter int unsigned AW = rf_wr_arbiter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          write,
  output logic [AW-1:0] writeregsel,
  output logic [DW-1:0] writedata,
  output logic          err
);

  import rf_wr_arbiter_pkg::*;

  logic          full0, full1;
  logic          age0, age1;
  logic [AW-1:0] reg0, reg1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, flip;
  logic          acc0, acc1;
  port_e         ptr_q;

  assign req0_ready = ~full0 | gnt0;
  assign req1_ready = ~full1 | gnt1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  rf_wr_slot #(.DW(DW), .AW(AW)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (acc0),
    .grant     (gnt0),
    .clear_age (gnt1),
    .set_age   (full1 & ~gnt1 & ~acc1),
    .in_reg    (req0_reg),
    .in_data   (req0_data),
    .full      (full0),
    .buf_reg   (reg0),
    .buf_data  (data0),
    .age       (age0)
  );

  rf_wr_slot #(.DW(DW), .AW(AW)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (acc1),
    .grant     (gnt1),
    .clear_age (gnt0),
    .set_age   (full0 & ~gnt0 & ~acc0),
    .in_reg    (req1_reg),
    .in_data   (req1_data),
    .full      (full1),
    .buf_reg   (reg1),
    .buf_data  (data1),
    .age       (age1)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    flip = 1'b0;
    unique case ({full1, full0})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        if (age0 != age1) begin
          gnt0 = ~age0;
          gnt1 = ~age1;
        end else if (reg0 == reg1) begin
          // Same-cycle WAW pair: execute result first so the load result lands last.
          gnt0 = 1'b1;
        end else begin
          flip = 1'b1;
          if (ptr_q == PORT_EX) gnt0 = 1'b1;
          else                  gnt1 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= PORT_EX;
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
      err         <= 1'b0;
    end else begin
      write <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        writeregsel <= gnt1 ? reg1  : reg0;
        writedata   <= gnt1 ? data1 : data0;
      end
      err <= acc0 & acc1 & (req0_reg == req1_reg);
      if (flip) begin
        ptr_q <= (ptr_q == PORT_EX) ? PORT_MEM : PORT_EX;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with literal expectations plus
// constrained-random traffic compared every cycle against a timestamp-based model.
module tb_rf_wr_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_reg, req1_reg;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          write, err;
  logic [AW-1:0] writeregsel;
  logic [DW-1:0] writedata;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_reg    (req0_reg),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_reg    (req1_reg),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .err         (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each buffered entry carries the cycle number it was loaded in;
  // the lower stamp is older. Equal stamps mean a same-cycle pair.
  bit            m_full [2];
  logic [AW-1:0] m_reg  [2];
  logic [DW-1:0] m_dat  [2];
  int            m_ts   [2];
  int            m_ptr = 0;
  int            m_t = 0;
  logic          m_write = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_sel = '0;
  logic [DW-1:0] m_wd = '0;

  initial begin
    int  g;
    bit  flip, rdy0, rdy1, a0, a1;
    m_full[0] = 0; m_full[1] = 0;
    forever begin
      @(negedge clk);
      #2;
      g = -1;
      flip = 0;
      if (m_full[0] && m_full[1]) begin
        if (m_ts[0] < m_ts[1])             g = 0;
        else if (m_ts[1] < m_ts[0])        g = 1;
        else if (m_reg[0] == m_reg[1])     g = 0;
        else begin g = m_ptr; flip = 1; end
      end else if (m_full[0]) g = 0;
      else if (m_full[1])     g = 1;
      rdy0 = !m_full[0] || g == 0;
      rdy1 = !m_full[1] || g == 1;
      if (model_on) begin
        chk("model_write",  32'(write),       32'(m_write));
        chk("model_sel",    32'(writeregsel), 32'(m_sel));
        chk("model_data",   32'(writedata),   32'(m_wd));
        chk("model_err",    32'(err),         32'(m_err));
        chk("model_ready0", 32'(req0_ready),  32'(rdy0));
        chk("model_ready1", 32'(req1_ready),  32'(rdy1));
      end
      a0 = req0_valid && rdy0;
      a1 = req1_valid && rdy1;
      if (rst) begin
        m_full[0] = 0; m_full[1] = 0;
        m_ptr = 0; m_write = 0; m_sel = '0; m_wd = '0; m_err = 0;
        model_on = 1'b1;
      end else begin
        m_write = (g >= 0);
        if (g >= 0) begin
          m_sel = m_reg[g];
          m_wd  = m_dat[g];
          m_full[g] = 0;
        end
        m_err = a0 && a1 && (req0_reg == req1_reg);
        if (flip) m_ptr = 1 - m_ptr;
        if (a0) begin m_full[0] = 1; m_reg[0] = req0_reg; m_dat[0] = req0_data; m_ts[0] = m_t; end
        if (a1) begin m_full[1] = 1; m_reg[1] = req1_reg; m_dat[1] = req1_data; m_ts[1] = m_t; end
      end
      m_t++;
    end
  end

  task automatic cyc(input bit v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                     input bit v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                     input bit r = 1'b0);
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    #2;
  endtask

  task automatic idle();
    cyc(0, '0, '0, 0, '0, '0);
  endtask

  task automatic expw(input string n, input logic [AW-1:0] sel, input logic [DW-1:0] d);
    chk({n, "_write"}, 32'(write),       32'd1);
    chk({n, "_sel"},   32'(writeregsel), 32'(sel));
    chk({n, "_data"},  32'(writedata),   32'(d));
  endtask

  task automatic pair(input bit r1_first);
    cyc(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB);
    chk("pair_ready0", 32'(req0_ready), 32'd1);
    chk("pair_ready1", 32'(req1_ready), 32'd1);
    idle();
    chk("pair_err", 32'(err), 32'd0);
    idle();
    if (r1_first) expw("pair_first", 3'd1, 16'hAAAA); else expw("pair_first", 3'd2, 16'hBBBB);
    idle();
    if (r1_first) expw("pair_second", 3'd2, 16'hBBBB); else expw("pair_second", 3'd1, 16'hAAAA);
  endtask

  initial begin
    bit p0, p1, wr0, wr1;
    rst = 1'b1;
    req0_valid = 0; req0_reg = '0; req0_data = '0;
    req1_valid = 0; req1_reg = '0; req1_data = '0;
    cyc(0, '0, '0, 0, '0, '0, 1'b1);
    cyc(0, '0, '0, 0, '0, '0, 1'b1);
    idle();
    chk("reset_write",  32'(write),       32'd0);
    chk("reset_sel",    32'(writeregsel), 32'd0);
    chk("reset_data",   32'(writedata),   32'd0);
    chk("reset_err",    32'(err),         32'd0);
    chk("reset_ready0", 32'(req0_ready),  32'd1);
    chk("reset_ready1", 32'(req1_ready),  32'd1);

    // Single write: visible two cycles after the request is presented, for one cycle.
    cyc(1, 3'd3, 16'h1234, 0, '0, '0);
    idle();
    chk("single_early", 32'(write), 32'd0);
    idle();
    expw("single", 3'd3, 16'h1234);
    idle();
    chk("single_once", 32'(write), 32'd0);

    // Streaming on port 0.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cyc(1, 3'd2, 16'(16'hA000 + i), 0, '0, '0);
        chk("stream_ready0", 32'(req0_ready), 32'd1);
      end else begin
        idle();
      end
      if (i >= 2) expw("stream", 3'd2, 16'(16'hA000 + i - 2));
    end
    idle();
    chk("stream_end", 32'(write), 32'd0);

    // Contention: pointer alternates between same-age pairs.
    pair(1'b1);
    pair(1'b0);
    pair(1'b1);

    // Ordering: pointer now favours port 1, so port 0's r6 stalls.
    cyc(1, 3'd6, 16'h0006, 1, 3'd2, 16'h0002);
    cyc(0, '0, '0, 1, 3'd5, 16'h0005);
    chk("order_ready0", 32'(req0_ready), 32'd0);
    chk("order_ready1", 32'(req1_ready), 32'd1);
    cyc(1, 3'd5, 16'h0050, 0, '0, '0);
    expw("order_w1", 3'd2, 16'h0002);
    chk("order_ready0b", 32'(req0_ready), 32'd1);
    idle();
    expw("order_w2", 3'd6, 16'h0006);
    idle();
    expw("order_w3", 3'd5, 16'h0005);
    idle();
    expw("order_w4", 3'd5, 16'h0050);

    // Same-cycle WAW to r4.
    cyc(1, 3'd4, 16'h1111, 1, 3'd4, 16'h2222);
    idle();
    chk("waw_err", 32'(err), 32'd1);
    idle();
    expw("waw_first", 3'd4, 16'h1111);
    chk("waw_err_clear", 32'(err), 32'd0);
    idle();
    expw("waw_last", 3'd4, 16'h2222);

    // Reset with both buffers holding entries.
    cyc(1, 3'd5, 16'h5A5A, 1, 3'd6, 16'h6B6B);
    cyc(0, '0, '0, 0, '0, '0, 1'b1);
    idle();
    chk("rst_mid_write",  32'(write),       32'd0);
    chk("rst_mid_sel",    32'(writeregsel), 32'd0);
    chk("rst_mid_data",   32'(writedata),   32'd0);
    chk("rst_mid_err",    32'(err),         32'd0);
    chk("rst_mid_ready0", 32'(req0_ready),  32'd1);
    chk("rst_mid_ready1", 32'(req1_ready),  32'd1);
    idle();
    chk("rst_mid_nowrite", 32'(write), 32'd0);
    idle();
    chk("rst_mid_nowrite2", 32'(write), 32'd0);

    // Random traffic; requesters hold their request until they see ready.
    p0 = 0; p1 = 0; wr0 = 0; wr1 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (p0 && wr0) p0 = 0;
      if (p1 && wr1) p1 = 0;
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1;
        req0_reg  = 3'($urandom_range(0, 3));
        req0_data = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1;
        req1_reg  = 3'($urandom_range(0, 3));
        req1_data = 16'($urandom);
      end
      req0_valid = p0;
      req1_valid = p1;
      rst = ($urandom_range(0, 63) == 0);
      #3;
      wr0 = req0_ready;
      wr1 = req1_ready;
    end
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: port 0 (execute/ALU result) and port 1 (memory/load result). Each port has a one-entry holding buffer with a valid/ready handshake. The block drives the register file's write, writeregsel and writedata inputs from registered outputs. It preserves write order between ports, arbitrates fairly between simultaneous requests, and flags same-cycle conflicting writes to the same register.

Parameters:
DW, 16, data width; must equal the register file write-data width
AW, 3, register-select width (8 registers)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req0_valid  in  1  port 0 has a write pending
req0_reg  in  AW  port 0 destination register
req0_data  in  DW  port 0 write data
req0_ready  out  1  port 0 buffer can accept this cycle
req1_valid  in  1  port 1 has a write pending
req1_reg  in  AW  port 1 destination register
req1_data  in  DW  port 1 write data
req1_ready  out  1  port 1 buffer can accept this cycle
write  out  1  register file write enable (registered)
writeregsel  out  AW  register file write select (registered)
writedata  out  DW  register file write data (registered)
err  out  1  one-cycle pulse: same-cycle accept on both ports with equal destination registers

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: both buffers empty, all age flags 0, round-robin pointer = port 0, write=0, writeregsel=0, writedata=0, err=0. Reset overrides any accept or grant in the same cycle. Buffered entries are discarded and not written.
- Per port i: buf_full_i, buf_reg_i, buf_data_i, age_i.
- Accept: valid_i & ready_i at a rising edge loads the buffer. ready_i = ~buf_full_i | grant_i, so ready is combinational on the grant.
- Age: on a load, age_i is set to 1 if the other buffer is full, is not granted this cycle, and is not being loaded in the same cycle. Otherwise age_i = 0. age_i = 1 means the other entry is older.
- Grant, combinational from the buffers:
  - Only one buffer full: grant that buffer.
  - Both full with different age: grant the entry with age 0.
  - Both full with equal age (loaded in the same cycle): grant the pointer's port, then flip the pointer.
  - Same-age pair with equal buf_reg: always grant port 0 first, so the load result lands last. The pointer does not flip.
- When the surviving entry is granted, clear its age.
- Output register, each edge: write <= any grant. writeregsel/writedata <= the granted entry's fields. When there is no grant, writeregsel/writedata hold their previous values.
- Latency: accept at edge E, write asserted in the cycle after edge E+1, i.e. 2 cycles.
- Throughput: an uncontended port sustains 1 write per cycle. Under contention, total throughput is still 1 write per cycle, shared between the two ports.
- err = 1 for exactly the cycle after an edge at which both ports were accepted with equal reg. Otherwise err = 0. err is not sticky.
- Back-pressure: a requester holds valid, reg and data stable until it sees ready. The block itself never drops an accepted entry.

Decomposition:
- Shared package: DW and AW constants, and the port index encoding (PORT_EX=0, PORT_MEM=1).
- One sub-module, rf_wr_slot: a per-port holding buffer (full, reg, data, age) with load/grant/clear inputs, instantiated twice.
- The grant logic and output register stay in the top module.

Test Plan:
- Reset mid-traffic: both buffers full, assert rst for 1 cycle. Next cycle: write=0, writeregsel=0, writedata=0, err=0, both readys=1; the buffered data never appears on the write port.
- Single port: req0 writes r3=0x1234 at edge E. write=1, writeregsel=3, writedata=0x1234 after edge E+1, for exactly one cycle.
- Streaming: req0 valid for 4 consecutive cycles with distinct data. req0_ready stays 1 and four back-to-back write cycles carry the data in order.
- Same-cycle contention, different regs: req0 r1=0xAAAA and req1 r2=0xBBBB both accepted at E. Write r1 then r2 (pointer=0). A repeat of the pair writes r2 first.
- Ordering: req1 r5=0x0005 accepted while req0's r6 entry is stalled behind a contention, then req0 r5=0x0050 accepted. The final write to r5 is 0x0050, following age order.
- WAW conflict: both ports write r4 in the same cycle (0x1111 from port 0, 0x2222 from port 1). err pulses for 1 cycle, port 0's 0x1111 is written first, and r4 ends at 0x2222.
